// File: rtl/display_clock_pkg.sv
// Shared definitions for the display-clock MMCM supervisor: state encoding,
// default timing values and a counter-width helper.
package display_clock_pkg;

    localparam logic [2:0] ST_RESET     = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAIL      = 3'd4;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 1000000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 4;
    localparam int DEF_CNT_W         = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Ceiling log2, never narrower than one bit so a degenerate config still elaborates.
    function automatic int clog2_w(input int value);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/display_clock_supervisor_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level, cleared to 0
// by a synchronous active-high reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next-value logic: plain shift of the input through two stages.
    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    // Synchronizer flops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/display_clock_supervisor.sv
// Display-clock MMCM supervisor: resets the MMCM, qualifies LOCKED and retries on timeout.
// Optional macro DISPLAY_CLOCK_FAULT_COUNTERS_EN enables the lock-loss/timeout counters.
module display_clock_supervisor
    import display_clock_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_mmcm_locked,
    input  logic             i_restart,
    output logic             o_mmcm_rst,
    output logic             o_clk_ok,
    output logic             o_fail,
    output logic [2:0]       o_state,
    output logic [3:0]       o_retry_cnt,
    output logic [CNT_W-1:0] o_loss_cnt,
    output logic [CNT_W-1:0] o_timeout_cnt
);

    localparam int CTR_W = clog2_w(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
    localparam logic [CTR_W-1:0] RST_LAST = CTR_W'(RST_CYCLES - 1);
    localparam logic [CTR_W-1:0] TMO_LAST = CTR_W'(LOCK_TIMEOUT - 1);
    localparam logic [CTR_W-1:0] STB_LAST = CTR_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

    logic             lk_s;
    logic [2:0]       state_q, state_d;
    logic [CTR_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;

    sync_2ff u_lock_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_mmcm_locked),
        .o_q   (lk_s)
    );

    // Next-state, phase counter and retry bookkeeping; restart overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        if (i_restart) begin
            state_d = ST_RESET;
            cnt_d   = '0;
            retry_d = 4'd0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CTR_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lk_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TMO_LAST) begin
                        cnt_d   = '0;
                        retry_d = retry_q + 4'd1;
                        state_d = ((retry_q + 4'd1) == RETRY_MAX) ? ST_FAIL : ST_RESET;
                    end else begin
                        cnt_d = cnt_q + CTR_W'(1);
                    end
                end
                ST_STABLE: begin
                    // A lock glitch only restarts the wait window; it is not a fault.
                    if (!lk_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STB_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        retry_d = 4'd0;
                    end else begin
                        cnt_d = cnt_q + CTR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lk_s) begin
                        state_d = ST_RESET;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                    retry_d = 4'd0;
                end
            endcase
        end
    end

    // FSM registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            retry_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    assign o_mmcm_rst  = (state_q == ST_RESET) || (state_q == ST_FAIL);
    assign o_clk_ok    = (state_q == ST_RUN);
    assign o_fail      = (state_q == ST_FAIL);
    assign o_state     = state_q;
    assign o_retry_cnt = retry_q;

`ifdef DISPLAY_CLOCK_FAULT_COUNTERS_EN
    logic             loss_evt_s;
    logic             tmo_evt_s;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;

    assign loss_evt_s = !i_restart && (state_q == ST_RUN) && !lk_s;
    assign tmo_evt_s  = !i_restart && (state_q == ST_WAIT_LOCK) && !lk_s && (cnt_q == TMO_LAST);

    // Saturating fault tallies; they survive restart and clear only on reset.
    always_comb begin
        loss_d = loss_q;
        tmo_d  = tmo_q;
        if (loss_evt_s && (loss_q != {CNT_W{1'b1}})) begin
            loss_d = loss_q + CNT_W'(1);
        end else begin
            loss_d = loss_q;
        end
        if (tmo_evt_s && (tmo_q != {CNT_W{1'b1}})) begin
            tmo_d = tmo_q + CNT_W'(1);
        end else begin
            tmo_d = tmo_q;
        end
    end

    // Fault counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            loss_q <= '0;
            tmo_q  <= '0;
        end else begin
            loss_q <= loss_d;
            tmo_q  <= tmo_d;
        end
    end

    assign o_loss_cnt    = loss_q;
    assign o_timeout_cnt = tmo_q;
`else
    assign o_loss_cnt    = '0;
    assign o_timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_display_clock_supervisor.sv
// Scoreboard bench for display_clock_supervisor: expected per-edge outputs are
// queued from the spec's timing and popped after every clock edge.
module tb_display_clock_supervisor;
    import display_clock_pkg::*;

    localparam int RC = 4;
    localparam int LT = 32;
    localparam int SC = 8;
    localparam int MR = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          locked;
    logic          restart;
    logic          mmcm_rst;
    logic          clk_ok;
    logic          fail;
    logic [2:0]    state;
    logic [3:0]    retry_cnt;
    logic [CW-1:0] loss_cnt;
    logic [CW-1:0] timeout_cnt;

    always #5 clk = ~clk;

    display_clock_supervisor #(
        .RST_CYCLES    (RC),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .MAX_RETRIES   (MR),
        .CNT_W         (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_mmcm_locked (locked),
        .i_restart     (restart),
        .o_mmcm_rst    (mmcm_rst),
        .o_clk_ok      (clk_ok),
        .o_fail        (fail),
        .o_state       (state),
        .o_retry_cnt   (retry_cnt),
        .o_loss_cnt    (loss_cnt),
        .o_timeout_cnt (timeout_cnt)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] retry;
        logic [3:0] loss;
        logic [3:0] tmo;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] loss_m;
    logic [3:0] tmo_m;
    logic [17:0] obs_s;

    assign obs_s = {state, clk_ok, mmcm_rst, fail, retry_cnt, loss_cnt, timeout_cnt};

    function automatic logic [3:0] fc(input logic [3:0] v);
`ifdef DISPLAY_CLOCK_FAULT_COUNTERS_EN
        return v;
`else
        return (v & 4'd0);
`endif
    endfunction

    function automatic logic [17:0] pack_exp(input exp_t e);
        return {e.st, (e.st == ST_RUN), (e.st == ST_RESET) || (e.st == ST_FAIL),
                (e.st == ST_FAIL), e.retry, fc(e.loss), fc(e.tmo)};
    endfunction

    task automatic push(input logic [2:0] st, input logic [3:0] retry, input int n);
        exp_t e;
        e.st = st;
        e.retry = retry;
        e.loss = loss_m;
        e.tmo = tmo_m;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loss_bump();
        if (loss_m != 4'd15) loss_m = loss_m + 4'd1;
    endtask

    // Reset values, reset pulse width, first lock latency (N+10).
    task automatic test_reset();
        exp_t e;
        int n;
        loss_m = 4'd0;
        tmo_m  = 4'd0;
        push(ST_RESET, 4'd0, 2 + 3);
        push(ST_WAIT_LOCK, 4'd0, 9);
        push(ST_STABLE, 4'd0, SC);
        push(ST_RUN, 4'd0, 4);
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            rst = (c <= 2);
            if (c == 13) locked = 1'b1;
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_s !== pack_exp(e)) begin
                n_bad++;
                $display("FAIL reset c=%0d got=%h want=%h", c, obs_s, pack_exp(e));
            end
        end
    endtask

    // One-cycle lock drop in RUN: RESET after 3 edges, loss counted, relock.
    task automatic test_lock_loss();
        exp_t e;
        int n;
        push(ST_RUN, 4'd0, 2);
        loss_bump();
        push(ST_RESET, 4'd0, RC);
        push(ST_WAIT_LOCK, 4'd0, 1);
        push(ST_STABLE, 4'd0, SC);
        push(ST_RUN, 4'd0, 3);
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            if (c == 1) locked = 1'b0;
            if (c == 2) locked = 1'b1;
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_s !== pack_exp(e)) begin
                n_bad++;
                $display("FAIL lock_loss c=%0d got=%h want=%h", c, obs_s, pack_exp(e));
            end
        end
    endtask

    // Restart from RUN, then a glitch after 5 STABLE cycles forces a fresh window.
    task automatic test_glitch();
        exp_t e;
        int n;
        push(ST_RESET, 4'd0, RC);
        push(ST_WAIT_LOCK, 4'd0, 1);
        push(ST_STABLE, 4'd0, 5);
        push(ST_WAIT_LOCK, 4'd0, 1);
        push(ST_STABLE, 4'd0, SC);
        push(ST_RUN, 4'd0, 3);
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            restart = (c == 1);
            if (c == 9)  locked = 1'b0;
            if (c == 10) locked = 1'b1;
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_s !== pack_exp(e)) begin
                n_bad++;
                $display("FAIL glitch c=%0d got=%h want=%h", c, obs_s, pack_exp(e));
            end
        end
    endtask

    // Twenty lock losses: loss counter stops at 15.
    task automatic test_saturation();
        exp_t e;
        for (int it = 0; it < 20; it++) begin
            push(ST_RUN, 4'd0, 2);
            loss_bump();
            push(ST_RESET, 4'd0, RC);
            push(ST_WAIT_LOCK, 4'd0, 1);
            push(ST_STABLE, 4'd0, SC);
            push(ST_RUN, 4'd0, 1);
            for (int c = 1; c <= 16; c++) begin
                if (c == 1) locked = 1'b0;
                if (c == 2) locked = 1'b1;
                tick();
                e = exp_q.pop_front();
                n_cmp++;
                if (obs_s !== pack_exp(e)) begin
                    n_bad++;
                    $display("FAIL saturation it=%0d c=%0d got=%h want=%h", it, c, obs_s, pack_exp(e));
                end
            end
        end
    endtask

    // No lock at all: three 36-cycle rounds, then FAIL with MMCM held in reset.
    task automatic test_timeout();
        exp_t e;
        int n;
        loss_m = 4'd0;
        tmo_m  = 4'd0;
        push(ST_RESET, 4'd0, 1 + 3);
        push(ST_WAIT_LOCK, 4'd0, LT);
        tmo_m = 4'd1;
        push(ST_RESET, 4'd1, RC);
        push(ST_WAIT_LOCK, 4'd1, LT);
        tmo_m = 4'd2;
        push(ST_RESET, 4'd2, RC);
        push(ST_WAIT_LOCK, 4'd2, LT);
        tmo_m = 4'd3;
        push(ST_FAIL, 4'd3, 5);
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            rst = (c == 1);
            locked = 1'b0;
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_s !== pack_exp(e)) begin
                n_bad++;
                $display("FAIL timeout c=%0d got=%h want=%h", c, obs_s, pack_exp(e));
            end
        end
    endtask

    // Restart out of FAIL keeps timeout count; restart coinciding with lock loss in RUN is not a loss.
    task automatic test_restart();
        exp_t e;
        int n;
        push(ST_FAIL, 4'd3, 3);
        push(ST_RESET, 4'd0, RC);
        push(ST_WAIT_LOCK, 4'd0, 1);
        push(ST_STABLE, 4'd0, SC);
        push(ST_RUN, 4'd0, 2 + 2);
        push(ST_RESET, 4'd0, RC);
        push(ST_WAIT_LOCK, 4'd0, 1);
        push(ST_STABLE, 4'd0, SC);
        push(ST_RUN, 4'd0, 3);
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            if (c == 1)  locked = 1'b1;
            if (c == 19) locked = 1'b0;
            if (c == 22) locked = 1'b1;
            restart = (c == 4) || (c == 21);
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_s !== pack_exp(e)) begin
                n_bad++;
                $display("FAIL restart c=%0d got=%h want=%h", c, obs_s, pack_exp(e));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        locked = 1'b0;
        restart = 1'b0;
        loss_m = 4'd0;
        tmo_m = 4'd0;
        test_reset();
        test_lock_loss();
        test_glitch();
        test_saturation();
        test_timeout();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_clock_supervisor.md
Name: display_clock_supervisor

Overview:
Sequences the display-clock MMCM. It drives the MMCM reset, watches the asynchronous LOCKED output, and declares the pixel clocks usable only after lock has held for a qualification window. It retries a bounded number of times when lock times out, and restarts the MMCM on lock loss. The block sits beside the display clock generator in the 100 MHz system domain. Its o_clk_ok output gates the display pipeline's reset.

Parameters:
RST_CYCLES, 16, cycles o_mmcm_rst is held high per reset attempt (min 1)
LOCK_TIMEOUT, 1000000, cycles allowed in WAIT_LOCK before declaring timeout (10 ms at 100 MHz)
STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before RUN
MAX_RETRIES, 4, timeouts tolerated before FAIL (1-15)
CNT_W, 8, width of fault counters

Ports:
i_clk  in  1  system clock, 100 MHz; all logic on rising edge
i_rst  in  1  reset, synchronous, active-high
i_mmcm_locked  in  1  MMCM LOCKED, asynchronous to i_clk
i_restart  in  1  single-cycle request to restart the MMCM from any state
o_mmcm_rst  out  1  MMCM RST, active-high
o_clk_ok  out  1  high only in RUN
o_fail  out  1  high only in FAIL
o_state  out  3  debug state encoding
o_retry_cnt  out  4  timeouts in the current bring-up attempt
o_loss_cnt  out  CNT_W  saturating count of lock losses while in RUN
o_timeout_cnt  out  CNT_W  saturating count of all lock timeouts

Behaviour:
- Clocking and reset: one clock, i_clk. i_rst is synchronous and active-high.
- i_rst=1 at an edge produces: state=RESET, phase counter=0, retry count=0, fault counters=0, synchronizer flops=0.
- Output reset values: o_mmcm_rst=1, o_clk_ok=0, o_fail=0, o_state=0, all counts 0.
- Lock synchronizer: i_mmcm_locked passes through a 2-flop synchronizer to produce lk. The FSM uses only lk.
- States and encoding: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- All outputs decode directly from registered state and counters, with no extra output register stage.
- RESET:
  - o_mmcm_rst=1.
  - Phase counter counts 0..RST_CYCLES-1, then go to WAIT_LOCK with counter cleared.
  - o_mmcm_rst is therefore high for exactly RST_CYCLES cycles after i_rst release.
- WAIT_LOCK:
  - o_mmcm_rst=0.
  - If lk=1, go to STABLE with counter cleared.
  - Otherwise, when the counter reaches LOCK_TIMEOUT-1: increment retry count and timeout count.
  - After that increment, if retry count equals MAX_RETRIES, go to FAIL; else go to RESET.
- STABLE:
  - If lk=0, return to WAIT_LOCK with counter cleared. This glitch is not counted and does not consume timeout budget beyond a fresh window.
  - After STABLE_CYCLES consecutive cycles with lk=1, go to RUN and clear retry count.
- RUN:
  - o_clk_ok=1.
  - If lk=0, go to RESET and increment loss count.
- FAIL:
  - o_mmcm_rst=1, o_fail=1.
  - Exit only via i_restart or i_rst.
- i_restart=1:
  - From any state: go to RESET, clear counter and retry count. Fault counters are kept.
  - i_restart has priority over every other transition.
  - Simultaneous lock loss in RUN is not counted.
  - i_restart while already in RESET restarts the RST_CYCLES window.
- Lock latency: let edge N be the first edge to sample i_mmcm_locked=1 in WAIT_LOCK. o_clk_ok is high after edge N+2+STABLE_CYCLES.
- Saturation: fault counters stop at 2^CNT_W-1 and never wrap.
- Counter widths: phase counter width is $clog2 of the largest of RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES.
- Domain note: o_clk_ok is in the i_clk domain. Pixel-domain consumers re-synchronize it.

Optional Feature:
DISPLAY_CLOCK_FAULT_COUNTERS_EN.
- Defined: o_loss_cnt and o_timeout_cnt are implemented as described above.
- Undefined: both outputs are tied to 0 and their registers are removed. FSM, o_retry_cnt and all timing are unchanged.

Decomposition:
- Shared package display_clock_pkg holds:
  - state encoding constants ST_RESET..ST_FAIL (3 bits)
  - default timing constants
  - clog2 helper for counter widths
- One sub-module, sync_2ff: a generic 2-flop synchronizer with synchronous reset to 0, used for i_mmcm_locked.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=3, CNT_W=4.
1. Release i_rst; raise i_mmcm_locked 10 cycles later and hold -> o_mmcm_rst high exactly 4 cycles after release; o_clk_ok high at edge N+10; o_retry_cnt=0.
2. Hold i_mmcm_locked=0 -> three RESET/WAIT_LOCK cycles of 36 cycles each; o_fail=1 and o_state=4 after the 3rd timeout; o_timeout_cnt=3; o_mmcm_rst stays 1.
3. In RUN, drop i_mmcm_locked for 1 cycle -> o_clk_ok falls 3 edges later; o_loss_cnt=1; o_mmcm_rst high for 4 cycles; relock returns to RUN.
4. In STABLE after 5 locked cycles, glitch lock low 1 cycle -> return to WAIT_LOCK; no counters change; RUN reached only after 8 fresh consecutive locked cycles.
5. In FAIL, pulse i_restart with lock good -> RESET; retry count 0; RUN reached; o_timeout_cnt retained. Also pulse i_restart in RUN on the same edge lk falls -> o_loss_cnt unchanged.
6. Force 20 lock losses -> o_loss_cnt saturates at 15. Rebuild without DISPLAY_CLOCK_FAULT_COUNTERS_EN -> o_loss_cnt and o_timeout_cnt always 0 and FSM trace identical.
